// File: rtl/vga_pkg.sv
// Shared VGA timing presets, sync polarity constants and a constant-time log2 helper.
package vga_pkg;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int unsigned VGA640_H_VISIBLE = 640;
    localparam int unsigned VGA640_H_FRONT   = 16;
    localparam int unsigned VGA640_H_SYNC    = 96;
    localparam int unsigned VGA640_H_BACK    = 48;
    localparam int unsigned VGA640_V_VISIBLE = 480;
    localparam int unsigned VGA640_V_FRONT   = 10;
    localparam int unsigned VGA640_V_SYNC    = 2;
    localparam int unsigned VGA640_V_BACK    = 33;

    // 800x600 @ 60 Hz, 40 MHz pixel clock, positive sync
    localparam int unsigned VGA800_H_VISIBLE = 800;
    localparam int unsigned VGA800_H_FRONT   = 40;
    localparam int unsigned VGA800_H_SYNC    = 128;
    localparam int unsigned VGA800_H_BACK    = 88;
    localparam int unsigned VGA800_V_VISIBLE = 600;
    localparam int unsigned VGA800_V_FRONT   = 1;
    localparam int unsigned VGA800_V_SYNC    = 4;
    localparam int unsigned VGA800_V_BACK    = 23;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with synchronous reset to a fixed pattern; DEPTH=0 is a wire.
module vga_delay_line
    import vga_pkg::*;
#(
    parameter int unsigned       WIDTH     = 1,
    parameter int unsigned       DEPTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Enable,
    input  logic [WIDTH-1:0] i_Data,
    output logic [WIDTH-1:0] o_Data
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{i_Clk, i_Reset, i_Enable};
        assign o_Data      = i_Data;
    end else begin : g_shift
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge i_Clk) begin
            if (i_Reset) begin
                for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
            end else if (i_Enable) begin
                stage[0] <= i_Data;
                for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign o_Data = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster: coordinates issued PIPE_DELAY cycles ahead of the registered
// sync/colour pins so a fixed-latency pixel source lines up with the syncs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = VGA640_H_VISIBLE,
    parameter int unsigned H_FRONT    = VGA640_H_FRONT,
    parameter int unsigned H_SYNC     = VGA640_H_SYNC,
    parameter int unsigned H_BACK     = VGA640_H_BACK,
    parameter int unsigned V_VISIBLE  = VGA640_V_VISIBLE,
    parameter int unsigned V_FRONT    = VGA640_V_FRONT,
    parameter int unsigned V_SYNC     = VGA640_V_SYNC,
    parameter int unsigned V_BACK     = VGA640_V_BACK,
    parameter logic        SYNC_POL   = SYNC_ACTIVE_LOW,
    parameter int unsigned COLOR_BITS = 3,
    parameter int unsigned PIPE_DELAY = 2,
    parameter int unsigned COORD_W    = 12
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic                  i_Enable,
    input  logic [COLOR_BITS-1:0] i_Red,
    input  logic [COLOR_BITS-1:0] i_Grn,
    input  logic [COLOR_BITS-1:0] i_Blu,
    output logic [COORD_W-1:0]    o_X,
    output logic [COORD_W-1:0]    o_Y,
    output logic                  o_Active,
    output logic                  o_Line_Start,
    output logic                  o_Frame_Start,
    output logic                  o_VGA_HSync,
    output logic                  o_VGA_VSync,
    output logic [COLOR_BITS-1:0] o_VGA_Red,
    output logic [COLOR_BITS-1:0] o_VGA_Grn,
    output logic [COLOR_BITS-1:0] o_VGA_Blu
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

    if (COORD_W < clog2(H_TOTAL) || COORD_W < clog2(V_TOTAL) || PIPE_DELAY > 15) begin : g_bad_params
        $error("vga_timing_gen: COORD_W too narrow or PIPE_DELAY out of range");
    end

    logic [COORD_W-1:0] x_cnt;
    logic [COORD_W-1:0] y_cnt;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (i_Enable) begin
            if (x_cnt == H_LAST) begin
                x_cnt <= '0;
                y_cnt <= (y_cnt == V_LAST) ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    logic hsync_lvl;
    logic vsync_lvl;
    logic active;

    always_comb begin
        hsync_lvl = (x_cnt >= HS_START && x_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync_lvl = (y_cnt >= VS_START && y_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
        active    = (x_cnt < H_VIS) && (y_cnt < V_VIS);
    end

    // Syncs travel at pin level so reset can preload the inactive level into every stage.
    logic [2:0] dly_out;

    vga_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
    ) u_delay (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Enable (i_Enable),
        .i_Data   ({hsync_lvl, vsync_lvl, active}),
        .o_Data   (dly_out)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_VGA_HSync <= ~SYNC_POL;
            o_VGA_VSync <= ~SYNC_POL;
            o_VGA_Red   <= '0;
            o_VGA_Grn   <= '0;
            o_VGA_Blu   <= '0;
        end else if (i_Enable) begin
            o_VGA_HSync <= dly_out[2];
            o_VGA_VSync <= dly_out[1];
            o_VGA_Red   <= dly_out[0] ? i_Red : '0;
            o_VGA_Grn   <= dly_out[0] ? i_Grn : '0;
            o_VGA_Blu   <= dly_out[0] ? i_Blu : '0;
        end
    end

    assign o_X           = x_cnt;
    assign o_Y           = y_cnt;
    assign o_Active      = active;
    assign o_Line_Start  = (x_cnt == '0);
    assign o_Frame_Start = (x_cnt == '0) && (y_cnt == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three rasters (640x480 default, 800x600 positive sync, tiny 25x15 bypass).
module tb_vga_timing_gen;

    typedef enum int {S_X, S_Y, S_ACT, S_LS, S_FS, S_HS, S_VS, S_RED, S_GRN, S_BLU} sig_e;
    typedef struct {
        int unsigned cyc;
        sig_e        sig;
        int          val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1, rst_c = 1'b1, en_a = 1'b1, flush = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0, errors = 0;
    exp_t        qa[$], qb[$], qc[$];

    logic [11:0] vx [3], vy [3];
    logic        vact [3], vls [3], vfs [3], vhs [3], vvs [3];
    logic [2:0]  vr [3], vg [3], vb [3];
    logic [2:0]  pa1, pa2, rin_a, bin_a, rin_c;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel source for A: colour = X mod 8, PIPE_DELAY=2 cycles of latency, stalls with enable
    always @(posedge clk) if (en_a) begin pa1 <= vx[0][2:0]; pa2 <= pa1; end
    assign rin_a = pa2;
    assign bin_a = ~pa2;
    assign rin_c = vx[2][2:0];

    vga_timing_gen dut_a (
        .i_Clk(clk), .i_Reset(rst_a), .i_Enable(en_a),
        .i_Red(rin_a), .i_Grn(3'd5), .i_Blu(bin_a),
        .o_X(vx[0]), .o_Y(vy[0]), .o_Active(vact[0]), .o_Line_Start(vls[0]), .o_Frame_Start(vfs[0]),
        .o_VGA_HSync(vhs[0]), .o_VGA_VSync(vvs[0]), .o_VGA_Red(vr[0]), .o_VGA_Grn(vg[0]), .o_VGA_Blu(vb[0])
    );

    vga_timing_gen #(
        .H_VISIBLE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
        .V_VISIBLE(600), .V_FRONT(1), .V_SYNC(4), .V_BACK(23),
        .SYNC_POL(1'b1), .COLOR_BITS(3), .PIPE_DELAY(1), .COORD_W(12)
    ) dut_b (
        .i_Clk(clk), .i_Reset(rst_a), .i_Enable(1'b1),
        .i_Red(3'd7), .i_Grn(3'd7), .i_Blu(3'd7),
        .o_X(vx[1]), .o_Y(vy[1]), .o_Active(vact[1]), .o_Line_Start(vls[1]), .o_Frame_Start(vfs[1]),
        .o_VGA_HSync(vhs[1]), .o_VGA_VSync(vvs[1]), .o_VGA_Red(vr[1]), .o_VGA_Grn(vg[1]), .o_VGA_Blu(vb[1])
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(3), .V_BACK(2),
        .SYNC_POL(1'b0), .COLOR_BITS(3), .PIPE_DELAY(0), .COORD_W(12)
    ) dut_c (
        .i_Clk(clk), .i_Reset(rst_c), .i_Enable(1'b1),
        .i_Red(rin_c), .i_Grn(3'd6), .i_Blu(3'd0),
        .o_X(vx[2]), .o_Y(vy[2]), .o_Active(vact[2]), .o_Line_Start(vls[2]), .o_Frame_Start(vfs[2]),
        .o_VGA_HSync(vhs[2]), .o_VGA_VSync(vvs[2]), .o_VGA_Red(vr[2]), .o_VGA_Grn(vg[2]), .o_VGA_Blu(vb[2])
    );

    function automatic int get(input int i, input sig_e s);
        case (s)
            S_X:     return int'(vx[i]);
            S_Y:     return int'(vy[i]);
            S_ACT:   return int'(vact[i]);
            S_LS:    return int'(vls[i]);
            S_FS:    return int'(vfs[i]);
            S_HS:    return int'(vhs[i]);
            S_VS:    return int'(vvs[i]);
            S_RED:   return int'(vr[i]);
            S_GRN:   return int'(vg[i]);
            default: return int'(vb[i]);
        endcase
    endfunction

    task automatic push(input int i, input int unsigned c, input sig_e s, input int v);
        exp_t e;
        e.cyc = c; e.sig = s; e.val = v;
        case (i)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic check(input int i, input exp_t e);
        int    act;
        string nm;
        act = get(i, e.sig);
        nm  = (i == 0) ? "A" : (i == 1) ? "B" : "C";
        checks++;
        if (e.cyc != cyc || act != e.val) begin
            errors++;
            $display("FAIL %s.%s at cycle %0d (due %0d): got %0d, expected %0d",
                     nm, e.sig.name(), cyc, e.cyc, act, e.val);
        end
    endtask

    // Monitor: compare every expectation whose cycle has arrived; flush forces leftovers out
    always @(negedge clk) begin
        while (qa.size() > 0 && (qa[0].cyc <= cyc || flush)) check(0, qa.pop_front());
        while (qb.size() > 0 && (qb[0].cyc <= cyc || flush)) check(1, qb.pop_front());
        while (qc.size() > 0 && (qc[0].cyc <= cyc || flush)) check(2, qc.pop_front());
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_reset_state(input int i, input int unsigned c, input int inactive);
        push(i, c, S_X, 0);   push(i, c, S_Y, 0);   push(i, c, S_ACT, 1);
        push(i, c, S_LS, 1);  push(i, c, S_FS, 1);  push(i, c, S_HS, inactive);
        push(i, c, S_VS, inactive); push(i, c, S_RED, 0); push(i, c, S_GRN, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: cycle %0d reached, expected finish well before", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r, rc;
        int p, px, py;
        bit vis;

        tick(2);
        r = cyc;
        push_reset_state(0, r, 1);
        push_reset_state(1, r, 0);
        rst_a = 1'b0;

        // A line 0: coordinates, then pins for pixel k-3
        for (int k = 1; k <= 802; k++) begin
            if (k inside {1, 639, 640, 799, 800, 801}) begin
                push(0, r+k, S_X, k % 800);          push(0, r+k, S_Y, k / 800);
                push(0, r+k, S_ACT, (k % 800 < 640) ? 1 : 0);
                push(0, r+k, S_LS, (k % 800 == 0) ? 1 : 0); push(0, r+k, S_FS, 0);
            end
            if (k < 3) begin
                push(0, r+k, S_RED, 0); push(0, r+k, S_GRN, 0); push(0, r+k, S_HS, 1);
            end else begin
                p   = k - 3;
                vis = (p < 640);
                push(0, r+k, S_RED, vis ? p % 8 : 0);
                push(0, r+k, S_GRN, vis ? 5 : 0);
                push(0, r+k, S_BLU, vis ? (~p) & 7 : 0);
                push(0, r+k, S_HS, (p >= 656 && p < 752) ? 0 : 1);
                push(0, r+k, S_VS, 1);
            end
        end
        // A line 1: 37-cycle stall at X=300, everything after shifted by 37
        for (int j = 1100; j <= 1137; j++) begin
            push(0, r+j, S_X, 300); push(0, r+j, S_Y, 1);
            push(0, r+j, S_RED, 1); push(0, r+j, S_GRN, 5); push(0, r+j, S_HS, 1);
        end
        for (int j = 1138; j <= 1639; j++) begin
            px = j - 840;
            if (j == 1138) push(0, r+j, S_X, 301);
            if (j == 1636) push(0, r+j, S_X, 799);
            if (j == 1637) begin
                push(0, r+j, S_X, 0); push(0, r+j, S_Y, 2);
                push(0, r+j, S_LS, 1); push(0, r+j, S_FS, 0);
            end
            push(0, r+j, S_RED, (px < 640) ? px % 8 : 0);
            push(0, r+j, S_HS, (px >= 656 && px < 752) ? 0 : 1);
        end
        // B: 800x600, positive sync, one pipe stage
        for (int k = 1; k <= 1057; k++) begin
            if (k == 1055) push(1, r+k, S_X, 1055);
            if (k == 1056) begin
                push(1, r+k, S_X, 0); push(1, r+k, S_Y, 1); push(1, r+k, S_LS, 1);
            end
            p = k - 2;
            push(1, r+k, S_HS, (k >= 2 && p >= 840 && p < 968) ? 1 : 0);
            push(1, r+k, S_VS, 0);
        end

        tick(r + 1100 - cyc);
        en_a = 1'b0;
        tick(37);
        en_a = 1'b1;

        // C: 25x15 raster, bypassed delay line, over one full frame plus most of the next
        tick(r + 1700 - cyc);
        rc = cyc;
        push_reset_state(2, rc, 1);
        rst_c = 1'b0;
        for (int k = 1; k <= 670; k++) begin
            push(2, rc+k, S_X, k % 25);               push(2, rc+k, S_Y, (k / 25) % 15);
            push(2, rc+k, S_LS, (k % 25 == 0) ? 1 : 0); push(2, rc+k, S_FS, (k % 375 == 0) ? 1 : 0);
            p   = k - 1;
            px  = p % 25;
            py  = (p / 25) % 15;
            vis = (px < 16 && py < 8);
            push(2, rc+k, S_RED, vis ? px % 8 : 0);
            push(2, rc+k, S_GRN, vis ? 6 : 0);
            push(2, rc+k, S_HS, (px >= 18 && px < 22) ? 0 : 1);
            push(2, rc+k, S_VS, (py >= 10 && py < 13) ? 0 : 1);
        end
        tick(670);
        rst_c = 1'b1;   // X=20, Y=11: inside both sync pulses
        tick(1);
        push_reset_state(2, cyc, 1);
        rst_c = 1'b0;
        push(2, cyc+1, S_X, 1); push(2, cyc+1, S_GRN, 6); push(2, cyc+1, S_RED, 0); push(2, cyc+1, S_HS, 1);
        push(2, cyc+2, S_X, 2); push(2, cyc+2, S_RED, 1);

        for (int n = 0; n < 200 && (qa.size() + qb.size() + qc.size()) > 0; n++) tick(1);
        flush = 1'b1;
        tick(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
